// File: rtl/pixel_scan_pkg.sv
// rtl/pixel_scan_pkg.sv - shared constants, field widths and counter-width helpers for the pixel scan blocks
package pixel_scan_pkg;

    localparam int DATA_W     = 32;
    localparam int HDR_SYNC_W = 8;
    localparam int HDR_RSVD_W = 8;
    localparam int HDR_FCNT_W = 16;

    localparam logic [HDR_SYNC_W-1:0] HDR_SYNC = 8'hA5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } pack_state_e;

    function automatic int RowCntWid(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // One extra code so the column counter can also hold COLUMN itself
    function automatic int ColCntWid(input int cols);
        return $clog2(cols + 1);
    endfunction

endpackage

// File: rtl/pixel_pack_fifo.sv
// rtl/pixel_pack_fifo.sv - synchronous output FIFO; a push into a full FIFO is accepted only alongside a pop
module pixel_pack_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_s,
    input  logic             rst_s,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full,
    output logic             empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  cnt_q;
    logic             do_rd, do_wr;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNTW'(DEPTH));
    assign do_rd     = rd_en_i & ~empty;
    assign do_wr     = wr_en_i & (~full | do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_readout_packer.sv
// rtl/pixel_readout_packer.sv - rebuilds one hit word per matrix row from the scanner's serial pixel stream
// Optional zero suppression of empty rows: define PIXEL_PACK_ZS_EN.
module pixel_readout_packer
    import pixel_scan_pkg::*;
#(
    parameter int ROW        = 400,
    parameter int COLUMN     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk_s,
    input  logic                      rst_s,
    input  logic                      speak_s,
    input  logic                      marker_a,
    input  logic                      pix_dout,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [RowCntWid(ROW)-1:0] out_row,
    output logic                      out_hdr,
    output logic                      overflow
);

    localparam int RW = RowCntWid(ROW);
    localparam int CW = ColCntWid(COLUMN);
    localparam int EW = DATA_W + RW + 1;

    pack_state_e             state_q, state_d;
    logic [CW-1:0]           col_idx_q, col_idx_d;
    logic [RW-1:0]           row_idx_q, row_idx_d, row_next;
    logic [DATA_W-1:0]       word_q, word_d, row_word, done_word;
    logic [HDR_FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                    last_bit_q, last_bit_d;
    logic                    overflow_q, overflow_d;
    logic                    row_done, row_keep, push;
    logic [EW-1:0]           push_data, head;
    logic                    fifo_full, fifo_empty;

    assign row_next   = (row_idx_q == RW'(ROW - 1)) ? '0 : row_idx_q + 1'b1;
    assign last_bit_d = speak_s ? pix_dout : last_bit_q;
    assign out_valid  = ~fifo_empty;
    assign overflow   = overflow_q;
    assign {out_hdr, out_row, out_data} = head;

`ifdef PIXEL_PACK_ZS_EN
    assign row_keep = |done_word;
`else
    assign row_keep = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        word_d      = word_q;
        frame_cnt_d = frame_cnt_q;
        row_done    = 1'b0;
        done_word   = '0;
        push        = 1'b0;
        push_data   = '0;
        row_word    = word_q;
        for (int i = 0; i < COLUMN; i++) begin
            if (col_idx_q == CW'(i)) begin
                row_word[i] = pix_dout;
            end
        end

        if (speak_s && marker_a) begin
            state_d     = ST_SCAN;
            col_idx_d   = CW'(2);
            row_idx_d   = '0;
            word_d      = '0;
            word_d[0]   = last_bit_q;
            word_d[1]   = pix_dout;
            frame_cnt_d = frame_cnt_q + 1'b1;
            push        = 1'b1;
            push_data   = {1'b1, {RW{1'b0}}, HDR_SYNC, {HDR_RSVD_W{1'b0}}, frame_cnt_q};
        end else if (speak_s && state_q == ST_SCAN) begin
            // col_idx==COLUMN only occurs for a two-column matrix, where the marker
            // already completed row 0; flush it now and start the next row at bit 0.
            if (col_idx_q == CW'(COLUMN)) begin
                row_done  = 1'b1;
                done_word = word_q;
                word_d    = '0;
                word_d[0] = pix_dout;
                col_idx_d = CW'(1);
                row_idx_d = row_next;
            end else if (col_idx_q == CW'(COLUMN - 1)) begin
                row_done  = 1'b1;
                done_word = row_word;
                word_d    = '0;
                col_idx_d = '0;
                row_idx_d = row_next;
            end else begin
                word_d    = row_word;
                col_idx_d = col_idx_q + 1'b1;
            end
        end

        if (row_done && row_keep) begin
            push      = 1'b1;
            push_data = {1'b0, row_idx_q, done_word};
        end
    end

    assign overflow_d = overflow_q | (push & fifo_full & ~(out_valid & out_ready));

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state_q     <= ST_IDLE;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            word_q      <= '0;
            frame_cnt_q <= '0;
            last_bit_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            word_q      <= word_d;
            frame_cnt_q <= frame_cnt_d;
            last_bit_q  <= last_bit_d;
            overflow_q  <= overflow_d;
        end
    end

    pixel_pack_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_s     (clk_s),
        .rst_s     (rst_s),
        .wr_en_i   (push),
        .wr_data_i (push_data),
        .rd_en_i   (out_ready),
        .rd_data_o (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_pixel_readout_packer.sv
// tb/tb_pixel_readout_packer.sv - randomized bench for pixel_readout_packer against a scanner-level reference model
module tb_pixel_readout_packer;

    localparam int ROW        = 4;
    localparam int COLUMN     = 8;
    localparam int FIFO_DEPTH = 4;

    logic        clk_s = 1'b0;
    logic        rst_s, speak_s, marker_a, pix_dout, out_ready;
    logic        out_valid, out_hdr, overflow;
    logic [31:0] out_data;
    logic [1:0]  out_row;

    always #5 clk_s = ~clk_s;

    pixel_readout_packer #(
        .ROW        (ROW),
        .COLUMN     (COLUMN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_s     (clk_s),
        .rst_s     (rst_s),
        .speak_s   (speak_s),
        .marker_a  (marker_a),
        .pix_dout  (pix_dout),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_hdr   (out_hdr),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        h;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];
    bit    hit [ROW][COLUMN];
    int    sr, sc, fcnt, hit_mode;
    int    checks = 0;
    int    errors = 0;
    bit    aligned, ovf_exp;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // mode 0: sparse random, 1: diagonal, 2: random with at least one hit per row
    task automatic regen();
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COLUMN; c++) begin
                hit[r][c] = (hit_mode == 1) ? (r == c) : ($urandom_range(0, 3) == 0);
            end
            if (hit_mode == 2) hit[r][$urandom_range(0, COLUMN - 1)] = 1'b1;
        end
    endtask

    function automatic logic [31:0] row_word(input int r);
        logic [31:0] w = '0;
        for (int c = 0; c < COLUMN; c++) w[c] = hit[r][c];
        return w;
    endfunction

    task automatic step(input bit spk, input bit rdy, input bit resync);
        word_t w;
        bit    push;
        check("valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("data", out_data, exp_q[0].d);
            check("row", out_row, exp_q[0].r);
            check("hdr", out_hdr, exp_q[0].h);
        end
        check("overflow", overflow, ovf_exp);
        if (out_valid && rdy) got_q.push_back(word_t'{out_data, out_row, out_hdr});

        if (resync) begin
            sr = 0;
            sc = 0;
            regen();
        end
        speak_s   = spk;
        out_ready = rdy;
        marker_a  = spk ? (sr == 0 && sc == 1) : 1'($urandom_range(0, 1));
        pix_dout  = spk ? hit[sr][sc] : 1'($urandom_range(0, 1));

        push = 1'b0;
        w    = '0;
        if (spk && marker_a) begin
            w.d     = {8'hA5, 8'h00, fcnt[15:0]};
            w.h     = 1'b1;
            push    = 1'b1;
            aligned = 1'b1;
            fcnt    = (fcnt + 1) % 65536;
        end else if (spk && aligned && sc == COLUMN - 1) begin
            w.d  = row_word(sr);
            w.r  = sr[1:0];
            push = 1'b1;
`ifdef PIXEL_PACK_ZS_EN
            if (w.d == 0) push = 1'b0;
`endif
        end
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
            else ovf_exp = 1'b1;
        end
        if (spk) begin
            sc++;
            if (sc == COLUMN) begin
                sc = 0;
                sr = (sr + 1) % ROW;
                if (sr == 0) regen();
            end
        end
        @(posedge clk_s);
        @(negedge clk_s);
    endtask

    task automatic do_reset(input int n);
        rst_s = 1'b1;
        exp_q.delete();
        aligned = 1'b0;
        fcnt    = 0;
        ovf_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            speak_s   = i[0];
            marker_a  = 1'($urandom_range(0, 1));
            pix_dout  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk_s);
            @(negedge clk_s);
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_row", out_row, 0);
            check("rst_hdr", out_hdr, 0);
            check("rst_overflow", overflow, 0);
        end
        rst_s = 1'b0;
        if (sr == 0 && sc == 1) sc = 2;
    endtask

    initial begin
        rst_s = 1'b1; speak_s = 1'b0; marker_a = 1'b0; pix_dout = 1'b0; out_ready = 1'b0;
        hit_mode = 0; sr = 0; sc = 0;
        regen();
        @(negedge clk_s);
        do_reset(4);

        // no marker: stays idle, nothing written
        sr = 1; sc = 3;
        repeat (40) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);

        // single diagonal frame, consumer always ready
        hit_mode = 1;
        do_reset(3);
        sr = 0; sc = 0;
        regen();
        got_q.delete();
        repeat (ROW * COLUMN) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check("d1_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            check("d1_hdr", {got_q[0].h, got_q[0].r, got_q[0].d}, {1'b1, 2'd0, 32'hA500_0000});
            for (int r = 0; r < ROW; r++)
                check("d1_word", {got_q[r+1].h, got_q[r+1].r, got_q[r+1].d}, {1'b0, 2'(r), 32'(1 << r)});
        end

        // backpressure through the whole frame
        do_reset(2);
        sr = 0; sc = 0;
        got_q.delete();
        repeat (ROW * COLUMN) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("d2_overflow", overflow, 1);
        got_q.delete();
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check("d2_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("d2_hdr", {got_q[0].h, got_q[0].d}, {1'b1, 32'hA500_0000});
            for (int r = 0; r < 3; r++)
                check("d2_word", {got_q[r+1].h, got_q[r+1].r, got_q[r+1].d}, {1'b0, 2'(r), 32'(1 << r)});
        end
        check("d2_overflow_sticky", overflow, 1);

        // resync after three columns of row 2
        hit_mode = 2;
        do_reset(2);
        sr = 0; sc = 0;
        regen();
        got_q.delete();
        repeat (2 * COLUMN + 3) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (COLUMN - 1) step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        check("d3_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            check("d3_r1", {got_q[2].h, got_q[2].r}, {1'b0, 2'd1});
            check("d3_hdr2", {got_q[3].h, got_q[3].d}, {1'b1, 32'hA500_0001});
            check("d3_row0", {got_q[4].h, got_q[4].r}, {1'b0, 2'd0});
        end

        // random traffic with occasional resync and reset
        hit_mode = 0;
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_reset(2);
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                     ($urandom_range(0, 149) == 0) && (sc <= COLUMN - 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_readout_packer.md
# pixel_readout_packer

Downstream companion of the pixel matrix scanner. It samples the shared column data line `pix_dout` on every scan strobe `speak_s`, and rebuilds one hit word per matrix row. Each frame opens with a header word carrying a frame counter, and words are queued in a small FIFO behind a valid/ready output port. It sits between the scanner/matrix and the chip's serial output framer.

## Interface
- `ROW`, 400, matrix rows; legal range 2..1024.
- `COLUMN`, 32, matrix columns; legal range 2..32. Unused high data bits read 0.
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥2.
- `clk_s`  in  1  scan clock, same clock as the scanner.
- `rst_s`  in  1  reset, asynchronous, active-high.
- `speak_s`  in  1  scan strobe, same signal that advances the scanner. Sample `pix_dout` on this cycle.
- `marker_a`  in  1  scanner frame marker. High on the `speak_s` cycle that samples pixel (row 0, col 1).
- `pix_dout`  in  1  hit bit of the currently selected pixel.
- `out_ready`  in  1  consumer accepts a word.
- `out_valid`  out  1  FIFO head is valid.
- `out_data`  out  32  header word or row hit word.
- `out_row`  out  clog2(ROW)  row index of a data word; 0 for a header.
- `out_hdr`  out  1  1 means `out_data` is a header.
- `overflow`  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- The FSM has two states.
  - IDLE: the state after reset. Samples are not assembled into words.
  - SCAN: the block is aligned to the scanner.
- `last_bit` register: loaded with `pix_dout` on every `speak_s` cycle, in any state.
- Frame start: a `speak_s` cycle with `marker_a`=1. It acts in either state.
  - Discard any partial row.
  - Set `col_idx`=2 and `row_idx`=0.
  - Seed the shift word with bit0=`last_bit` and bit1=`pix_dout`.
  - Write the header word {8'hA5, 8'h00, `frame_cnt`[15:0]} with `out_hdr`=1.
  - Increment `frame_cnt`. It is 16 bits and wraps 0xFFFF→0x0000. The first header after reset carries 0.
  - Go to SCAN.
- Each `speak_s` cycle in SCAN without `marker_a`:
  - Store `pix_dout` into bit `col_idx` of the row word.
  - If `col_idx`==COLUMN-1, the row is complete:
    - Write {zero-pad, word} with `out_row`=`row_idx`.
    - Set `col_idx`=0.
    - `row_idx` wraps from ROW-1 to 0. Otherwise `row_idx` increments.
  - Otherwise increment `col_idx`.
- Bit *i* of a data word is column *i*.
- FIFO writes:
  - Header writes and row writes never coincide, because COLUMN≥2.
  - A write while the FIFO is full is dropped and sets `overflow`. `overflow` is cleared only by `rst_s`.
  - A pop and a push in the same cycle while full: the push succeeds.
- Output handshake: a word transfers on a cycle with `out_valid`&`out_ready`. `out_data`, `out_row` and `out_hdr` are held stable while `out_valid`=1 and `out_ready`=0.
- If `rst_s` is asserted mid-frame: FSM returns to IDLE, FIFO empties, counters and `frame_cnt` are cleared, and `overflow` is cleared.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_hdr`=0, `overflow`=0.
- Write latency: the word is written at the clock edge ending its final `speak_s` cycle (edge E). `out_valid` rises in the cycle after E if the FIFO was empty.
- `overflow` rises in the cycle after the dropped write.
- `speak_s` may be high on consecutive cycles. There is no minimum gap.
- `marker_a` is ignored when `speak_s`=0.

## Configuration
- `PIXEL_PACK_ZS_EN` defined: zero suppression is on.
  - Row words equal to 0 are not written.
  - Dropped zero rows do not set `overflow`.
  - Header words are always written.
- `PIXEL_PACK_ZS_EN` undefined: every row word is written, ROW data words per frame.

## Structure
- Shared package `pixel_scan_pkg` holds:
  - `HDR_SYNC`=8'hA5;
  - the header field widths;
  - the `RowCntWid`/`ColCntWid` helpers, derived with `$clog2`.
- Sub-module `pixel_pack_fifo`: synchronous FIFO, registered head.
  - Entry width 32+clog2(ROW)+1.
  - Outputs `full`/`empty`.

## Test plan
- Reset check. Assert `rst_s` with `speak_s` toggling → all outputs 0. No writes while IDLE.
- Single frame, ROW=4, COLUMN=8, `out_ready`=1.
  - Stimulus: row r has `pix_dout`=1 only at col r.
  - Response: header 0xA5000000, then data 0x01/r0, 0x02/r1, 0x04/r2, 0x08/r3.
- Backpressure, FIFO_DEPTH=4. Hold `out_ready`=0 through the frame → first 4 words are retained and `overflow`=1. Then release `out_ready` → those 4 words emerge in order.
- Mid-row resync. Assert a marker after 3 columns of row 2 → partial row discarded, new header with `frame_cnt`+1, next data word is row 0.
- Frame counter wrap. Run 65537 frames with ROW=2, COLUMN=2 → header fields go 0xFFFF then 0x0000.
- `PIXEL_PACK_ZS_EN` defined. Hits only in row 2 → header plus exactly one data word with `out_row`=2.
